// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller with edge/level sources, pending/mask/mode
// registers, and an IDLE -> REQ -> SERV handshake with ack and end-of-interrupt.
module int_ctrl #(
  parameter int NSRC = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [29:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic            int_ack,
  output logic            irq_out,
  output logic [1:0]      irq_id,
  output logic            in_service
);

  // state | meaning
  // IDLE  | no request outstanding, picking the next winner
  // REQ   | irq_out high, waiting for int_ack
  // SERV  | CPU is serving irq_id, waiting for an EOI write to VEC
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          state;
  logic [NSRC-1:0] irq_q, pending, mask, mode;
  logic [NSRC-1:0] edge_det, eligible, w1c, ack_clr, pend_nxt;
  logic [1:0]      winner;
  logic            id_elig, eoi;
  logic            unused_bits;

  assign unused_bits = ^{Addr[29:2], Din[31:NSRC]};

  assign edge_det = irq_in & ~irq_q;
  assign eligible = pending & mask;
  assign id_elig  = eligible[irq_id];
  assign eoi      = WE && (Addr[1:0] == 2'd3);
  assign w1c      = (WE && (Addr[1:0] == 2'd0)) ? Din[NSRC-1:0] : '0;

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (eligible[i]) winner = 2'(i);
  end

  // Level sources just track irq_in; edge sources latch until cleared, set wins.
  always_comb begin
    ack_clr  = '0;
    pend_nxt = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i]  = (state == REQ) && int_ack && (irq_id == 2'(i));
      pend_nxt[i] = mode[i] ? irq_in[i]
                            : (edge_det[i] | (pending[i] & ~w1c[i] & ~ack_clr[i]));
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[1:0])
      2'd0: Dout[NSRC-1:0] = pending;
      2'd1: Dout[NSRC-1:0] = mask;
      2'd2: Dout[NSRC-1:0] = mode;
      default: Dout[4:0] = {in_service, irq_out, 1'b0, irq_id};
    endcase
  end

  // irq_q follows irq_in even during reset so a held line never looks like a rise.
  always_ff @(posedge clk) irq_q <= irq_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      mask       <= '0;
      mode       <= '0;
      irq_id     <= '0;
      irq_out    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (WE && (Addr[1:0] == 2'd1)) mask <= Din[NSRC-1:0];
      if (WE && (Addr[1:0] == 2'd2)) mode <= Din[NSRC-1:0];
      case (state)
        IDLE: begin
          if (eligible != '0) begin
            state   <= REQ;
            irq_id  <= winner;
            irq_out <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERV;
            irq_out    <= 1'b0;
            in_service <= 1'b1;
          end else if (!id_elig) begin
            state   <= IDLE;
            irq_out <= 1'b0;
            irq_id  <= '0;
          end
        end
        SERV: begin
          if (eoi) begin
            state      <= IDLE;
            in_service <= 1'b0;
            irq_id     <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          irq_out    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
